// File: rtl/bus_seq_pkg.sv
// bus_seq_pkg: shared state encoding, widths and reset constants for the bus sequencer
package bus_seq_pkg;

    localparam int BUS_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        EXEC   = 3'd2,
        DATA   = 3'd3,
        COMMIT = 3'd4,
        TRAP   = 3'd5
    } state_t;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/bus_sequencer_if.sv
// bus_sequencer_if: unified memory bus (request/acknowledge handshake) between sequencer and memory
interface bus_sequencer_if #(
    parameter int WIDTH = 32
);

    logic             req;
    logic             we;
    logic [WIDTH-1:0] addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             ack;

    modport master(output req, we, addr, wdata, input rdata, ack);
    modport slave(input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/retire_cntr.sv
// retire_cntr: free-running retired-instruction counter, wraps modulo 2^WIDTH
module retire_cntr
    import bus_seq_pkg::*;
#(
    parameter int WIDTH = BUS_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    // count one per commit pulse, cleared asynchronously
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) cnt_q <= '0;
        else if (en_i) cnt_q <= cnt_q + WIDTH'(1);
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/bus_sequencer.sv
// bus_sequencer: shares one memory bus between instruction fetch and data access for a single-cycle core
module bus_sequencer
    import bus_seq_pkg::*;
#(
    parameter int               WIDTH = BUS_W,
    parameter logic [WIDTH-1:0] NOP   = NOP_INSTR
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [WIDTH-1:0]       instr_addr_i,
    output logic [WIDTH-1:0]       instr_data_o,
    input  logic                   mem_we_i,
    input  logic                   mem_re_i,
    input  logic [WIDTH-1:0]       mem_addr_i,
    input  logic [WIDTH-1:0]       mem_data_i,
    output logic [WIDTH-1:0]       mem_data_o,
    output logic                   core_en_o,
    bus_sequencer_if.master        bus,
    output logic                   err_o,
    output logic [WIDTH-1:0]       instret_o
);

    state_t           state_q;
    logic [WIDTH-1:0] ir_q;
    logic [WIDTH-1:0] rdata_q;
    logic             fetch_req;
    logic             data_req;
    logic             mem_op;

    assign mem_op    = mem_we_i || mem_re_i;
    assign fetch_req = state_q == FETCH && !misaligned(instr_addr_i[1:0]);
    assign data_req  = state_q == DATA && !misaligned(mem_addr_i[1:0]);

    // bus drive is decoded from state; a misaligned address never reaches the bus
    always_comb begin
        bus.req   = fetch_req || data_req;
        bus.we    = data_req && mem_we_i;
        bus.addr  = fetch_req ? instr_addr_i : data_req ? mem_addr_i : '0;
        bus.wdata = data_req ? mem_data_i : '0;
    end

    // sequencer: fetch, let the core decode, optional data access, then commit
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            ir_q    <= NOP;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE:    state_q <= FETCH;
                FETCH: begin
                    if (misaligned(instr_addr_i[1:0])) begin
                        state_q <= TRAP;
                    end else if (bus.ack) begin
                        ir_q    <= bus.rdata;
                        state_q <= EXEC;
                    end
                end
                EXEC:    state_q <= mem_op ? DATA : FETCH;
                DATA: begin
                    if (misaligned(mem_addr_i[1:0])) begin
                        state_q <= TRAP;
                    end else if (bus.ack) begin
                        if (!mem_we_i && mem_re_i) rdata_q <= bus.rdata;
                        state_q <= COMMIT;
                    end
                end
                COMMIT:  state_q <= FETCH;
                default: state_q <= TRAP;
            endcase
        end
    end

    assign core_en_o    = (state_q == EXEC && !mem_op) || state_q == COMMIT;
    assign err_o        = state_q == TRAP;
    assign instr_data_o = ir_q;
    assign mem_data_o   = rdata_q;

    retire_cntr #(.WIDTH(WIDTH)) u_retire (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en_i  (core_en_o),
        .cnt_o (instret_o)
    );

endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: random program run against a scoreboard, then directed corner cases
module tb_bus_sequencer;
    import bus_seq_pkg::*;

    localparam int N = 80;

    typedef struct {
        logic [31:0] instr;
        bit          ld;
        logic [31:0] ldata;
        int          lat;
    } ret_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    bus_sequencer_if #(.WIDTH(32)) bus ();

    logic [31:0] instr_addr, instr_data, mem_addr, mem_wdata, mem_rdata, instret;
    logic        mem_we, mem_re, core_en, err;

    bus_sequencer dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .instr_addr_i (instr_addr),
        .instr_data_o (instr_data),
        .mem_we_i     (mem_we),
        .mem_re_i     (mem_re),
        .mem_addr_i   (mem_addr),
        .mem_data_i   (mem_wdata),
        .mem_data_o   (mem_rdata),
        .core_en_o    (core_en),
        .bus          (bus),
        .err_o        (err),
        .instret_o    (instret)
    );

    int n_chk = 0;
    int n_fail = 0;

    logic        man = 1'b0;
    logic        m_we = 1'b0, m_re = 1'b0, m_ack = 1'b0;
    logic [31:0] m_pc = '0, m_addr = '0, m_wdata = '0, m_rdata = '0;
    logic        r_ack = 1'b0;
    logic [31:0] r_rdata = '0;

    int          idx = 0;
    int          nret = 0;
    logic [31:0] p_daddr [N+1];
    logic [31:0] p_wdata [N+1];
    bit   [31:0] bus_mem [bit [31:0]];
    logic [31:0] ref_mem [16];
    int          wq[$];
    logic [63:0] wr_q[$];
    ret_t        ret_q[$];

    assign instr_addr = man ? m_pc : {idx[29:0], 2'b00};
    assign mem_we     = man ? m_we : instr_data[6:0] == 7'h23;
    assign mem_re     = man ? m_re : instr_data[6:0] == 7'h03;
    assign mem_addr   = man ? m_addr : p_daddr[idx];
    assign mem_wdata  = man ? m_wdata : p_wdata[idx];
    assign bus.ack    = man ? m_ack : r_ack;
    assign bus.rdata  = man ? m_rdata : r_rdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // memory responder for the random phase: per-access wait counts, stray acks while idle
    initial begin
        int cnt = 0;
        bit p_req = 0, p_we = 0;
        logic [31:0] p_addr = '0, p_wd = '0;
        logic [63:0] w;
        forever begin
            @(negedge clk);
            if (!rst_n || man) begin
                cnt = 0; p_req = 0; r_ack = 0;
            end else begin
                if (p_req && r_ack) begin
                    if (p_we) begin
                        bus_mem[p_addr] = p_wd;
                        if (wr_q.size() == 0) begin
                            chk("unexpected write", p_addr, 32'hFFFF_FFFF);
                        end else begin
                            w = wr_q.pop_front();
                            chk("write addr", p_addr, w[63:32]);
                            chk("write data", p_wd, w[31:0]);
                        end
                    end
                    if (wq.size() != 0) void'(wq.pop_front());
                    cnt = 0;
                end else if (p_req) cnt++;
                p_req = bus.req; p_we = bus.we; p_addr = bus.addr; p_wd = bus.wdata;
                if (bus.req && cnt == (wq.size() != 0 ? wq[0] : 0)) begin
                    r_ack   = 1'b1;
                    r_rdata = bus_mem.exists(bus.addr) ? bus_mem[bus.addr] : 32'h0;
                end else begin
                    r_ack   = !bus.req && $urandom_range(0, 3) == 0;
                    r_rdata = $urandom();
                end
            end
        end
    end

    // retire monitor: each commit pulse is matched against the next expected retirement
    initial begin
        int cyc = 0;
        ret_t e;
        forever begin
            @(negedge clk);
            if (rst_n && !man) begin
                cyc++;
                if (core_en) begin
                    if (ret_q.size() == 0) begin
                        chk("extra retire", instret, 32'hFFFF_FFFF);
                    end else begin
                        e = ret_q.pop_front();
                        chk("instret", instret, 32'(nret));
                        chk("ir at retire", instr_data, e.instr);
                        if (e.ld) chk("load data", mem_rdata, e.ldata);
                        chk("latency", 32'(cyc), 32'(e.lat));
                    end
                    cyc = 0;
                    nret++;
                    @(posedge clk);
                    #1 idx++;
                end
            end else cyc = 0;
        end
    end

    task automatic run(input logic [31:0] ins, input logic we, input logic re, input logic [31:0] a,
                       input logic [31:0] d, input int fw, input int dw, input logic [31:0] ld,
                       output int done, output int cyc, output int ndreq, output int nwr, output int nbad);
        int fwc = 0, dwc = 0;
        bit fetched = 0;
        done = 0; cyc = 0; ndreq = 0; nwr = 0; nbad = 0;
        m_we = we; m_re = re; m_addr = a; m_wdata = d;
        for (int k = 0; k < 12 && done == 0; k++) begin
            cyc++;
            m_ack = 1'b0;
            if (core_en) done = 1;
            else if (bus.req && !fetched) begin
                if (bus.we !== 1'b0 || bus.addr !== m_pc) nbad++;
                if (fwc == fw) begin m_ack = 1'b1; m_rdata = ins; fetched = 1; end
                else fwc++;
            end else if (bus.req) begin
                ndreq++;
                if (bus.we !== we || bus.addr !== a || (we && bus.wdata !== d)) nbad++;
                if (dwc == dw) begin m_ack = 1'b1; m_rdata = ld; if (we) nwr++; end
                else begin dwc++; m_rdata = $urandom(); end
            end
            if (done == 0) @(negedge clk);
        end
        m_ack = 1'b0;
    endtask

    initial begin
        int done, cyc, ndreq, nwr, nbad;
        int kind, fw, dw, di;
        logic [31:0] r, ins;
        logic [6:0] op;
        ret_t e;

        for (int j = 0; j < 16; j++) begin
            r = $urandom();
            bus_mem[32'h1000 + 32'(j * 4)] = r;
            ref_mem[j] = r;
        end
        for (int i = 0; i < N; i++) begin
            kind = $urandom_range(0, 2);
            op   = kind == 0 ? 7'h13 : kind == 1 ? 7'h03 : 7'h23;
            r    = $urandom();
            ins  = {r[31:7], op};
            di   = $urandom_range(0, 15);
            fw   = $urandom_range(0, 3);
            dw   = $urandom_range(0, 3);
            p_daddr[i] = 32'h1000 + 32'(di * 4);
            p_wdata[i] = $urandom();
            bus_mem[32'(i * 4)] = ins;
            wq.push_back(fw);
            if (kind != 0) wq.push_back(dw);
            e.instr = ins;
            e.ld    = kind == 1;
            e.ldata = ref_mem[di];
            e.lat   = (i == 0 ? 1 : 0) + 2 + fw + (kind != 0 ? 2 + dw : 0);
            if (kind == 2) begin
                ref_mem[di] = p_wdata[i];
                wr_q.push_back({p_daddr[i], p_wdata[i]});
            end
            ret_q.push_back(e);
        end
        p_daddr[N] = '0;
        p_wdata[N] = '0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 5000 && nret < N; k++) @(posedge clk);
        #1 man = 1'b1;
        rst_n = 1'b0;
        chk("random run retired", 32'(nret), 32'(N));
        chk("writes drained", 32'(wr_q.size()), 32'h0);

        #1;
        chk("reset req", {31'h0, bus.req}, 32'h0);
        chk("reset addr", bus.addr, 32'h0);
        chk("reset core_en", {31'h0, core_en}, 32'h0);
        chk("reset err", {31'h0, err}, 32'h0);
        chk("reset instret", instret, 32'h0);
        chk("reset ir", instr_data, NOP_INSTR);
        chk("reset rdata", mem_rdata, 32'h0);

        m_pc = 32'h0; m_we = 0; m_re = 0; m_ack = 1'b1; m_rdata = 32'hBAD0_0001;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("idle req", {31'h0, bus.req}, 32'h0);
        @(negedge clk);
        chk("fetch req", {31'h0, bus.req}, 32'h1);
        chk("fetch addr", bus.addr, 32'h0);
        chk("idle ack ignored", instr_data, NOP_INSTR);
        m_rdata = 32'h0050_0093;
        @(negedge clk);
        chk("exec ir", instr_data, 32'h0050_0093);
        chk("alu commit", {31'h0, core_en}, 32'h1);
        chk("exec req", {31'h0, bus.req}, 32'h0);
        m_rdata = 32'hBAD0_0002;
        @(negedge clk);
        m_ack = 1'b0;
        chk("exec ack ignored", instr_data, 32'h0050_0093);
        chk("instret one", instret, 32'h1);
        chk("single pulse", {31'h0, core_en}, 32'h0);

        run(32'h0400_2083, 0, 1, 32'h40, 32'h0, 0, 2, 32'hDEAD_BEEF, done, cyc, ndreq, nwr, nbad);
        chk("load done", 32'(done), 32'h1);
        chk("load latency", 32'(cyc), 32'h6);
        chk("load req cycles", 32'(ndreq), 32'h3);
        chk("load bus hold", 32'(nbad), 32'h0);
        chk("load rdata", mem_rdata, 32'hDEAD_BEEF);
        @(negedge clk);

        run(32'h0420_2223, 1, 0, 32'h44, 32'h1234_5678, 1, 2, 32'h0, done, cyc, ndreq, nwr, nbad);
        chk("store latency", 32'(cyc), 32'h7);
        chk("store writes", 32'(nwr), 32'h1);
        chk("store bus hold", 32'(nbad), 32'h0);
        chk("store rdata kept", mem_rdata, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("instret three", instret, 32'h3);

        run(32'h0420_2083, 0, 1, 32'h42, 32'h0, 0, 0, 32'h0, done, cyc, ndreq, nwr, nbad);
        chk("misaligned no commit", 32'(done), 32'h0);
        chk("misaligned no req", 32'(ndreq), 32'h0);
        chk("misaligned err", {31'h0, err}, 32'h1);
        chk("trap instret", instret, 32'h3);
        rst_n = 1'b0;
        #1 chk("reset clears err", {31'h0, err}, 32'h0);

        m_pc = 32'h2; m_we = 0; m_re = 0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("misaligned fetch req", {31'h0, bus.req}, 32'h0);
        @(negedge clk);
        chk("fetch trap err", {31'h0, err}, 32'h1);
        rst_n = 1'b0;

        m_pc = 32'h0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        run(32'h00A0_0113, 0, 0, 32'h0, 32'h0, 0, 0, 32'h0, done, cyc, ndreq, nwr, nbad);
        chk("alu latency", 32'(cyc), 32'h2);
        @(negedge clk);
        @(negedge clk);
        chk("wait req held", {31'h0, bus.req}, 32'h1);
        chk("pre-reset ir", instr_data, 32'h00A0_0113);
        chk("pre-reset instret", instret, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid-fetch reset req", {31'h0, bus.req}, 32'h0);
        chk("mid-fetch reset ir", instr_data, NOP_INSTR);
        chk("mid-fetch reset instret", instret, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_sequencer.md
# bus_sequencer

Multi-cycle sequencer that lets the single-cycle RV32 datapath share one unified, variable-latency memory bus for both instruction fetch and data access. It fetches an instruction into a held instruction register and presents it to the core. When the core flags a load or store, it runs a second bus transaction. It then emits a one-cycle commit enable that gates the PC update and the register-file write. It sits between the core's instruction/data ports and the single external memory port.

## Interface
- WIDTH, 32, address/data width
- NOP, 32'h0000_0013, instruction register reset/idle value (addi x0,x0,0)
- clk_i  in  1  system clock, all state on rising edge
- rst_i  in  1  reset, asynchronous, active-low
- instr_addr_i  in  WIDTH  core PC
- instr_data_o  out  WIDTH  held instruction to core decode/extend/regfile
- mem_we_i  in  1  core store strobe (from control unit)
- mem_re_i  in  1  core load flag (control unit resultsrc, exported)
- mem_addr_i  in  WIDTH  core data address (ALU result)
- mem_data_i  in  WIDTH  core store data (rd2)
- mem_data_o  out  WIDTH  registered load data to core result mux
- core_en_o  out  1  commit pulse; drives pc en and gates regwrite
- bus_req_o  out  1  bus request
- bus_we_o  out  1  bus write
- bus_addr_o  out  WIDTH  bus address
- bus_wdata_o  out  WIDTH  bus write data
- bus_rdata_i  in  WIDTH  bus read data, valid with ack
- bus_ack_i  in  1  bus acknowledge
- err_o  out  1  sticky misalignment fault
- instret_o  out  WIDTH  retired-instruction counter

## Operation
- States: IDLE, FETCH, EXEC, DATA, COMMIT, TRAP.
- Reset: state IDLE, ir=NOP, rdata=0, instret=0, err=0. All bus outputs 0, core_en_o=0.
- IDLE: goes to FETCH next cycle, no condition.
- FETCH: bus_req_o=1, bus_we_o=0, bus_addr_o=instr_addr_i. If instr_addr_i[1:0]!=0, go to TRAP without requesting (req=0 that cycle). On ack, ir<=bus_rdata_i and go to EXEC.
- EXEC: the core decodes ir combinationally. mem_we_i has priority over mem_re_i. If either is set, go to DATA. Otherwise core_en_o=1, instret++, and go to FETCH.
- DATA: bus_req_o=1, bus_we_o=mem_we_i, bus_addr_o=mem_addr_i, bus_wdata_o=mem_data_i. If mem_addr_i[1:0]!=0, go to TRAP without requesting. On ack: for a load, rdata<=bus_rdata_i. Then go to COMMIT.
- COMMIT: core_en_o=1, instret++, go to FETCH. mem_data_o=rdata is stable this cycle.
- TRAP: err_o=1. All requests stay at 0 and core_en_o=0 until reset.
- Idle bus values: when bus_req_o=0, bus_we_o, bus_addr_o and bus_wdata_o are 0.
- instret wraps modulo 2^WIDTH.

## Timing
- bus_req_o, bus_we_o, bus_addr_o and bus_wdata_o are decoded combinationally from state and core inputs. The core inputs are stable while req=1 because PC and ir are registered.
- Handshake: req stays high until ack is sampled high at a rising edge. Ack is ignored when req=0. Memory may ack in the first req cycle (zero wait).
- Zero-wait latency: 2 cycles for ALU/branch (FETCH, EXEC) and 4 cycles for load/store (FETCH, EXEC, DATA, COMMIT). Each wait cycle adds 1.
- core_en_o is exactly one cycle per retired instruction.
- The PC and register file update on the edge that ends the core_en_o cycle.
- Asynchronous reset mid-transaction drops req immediately and abandons the access. After release, one IDLE cycle precedes the first FETCH.

## Structure
- Shared package bus_seq_pkg holds the state enum (3-bit encoding) and the NOP constant.
- One sub-module is natural: retire_cntr, a WIDTH-bit enable counter with async active-low clear.
- The FSM, ir and rdata live in the top module.

## Test plan
- Reset release, PC=0, memory returns addi x1,x0,5 with zero wait: req rises one cycle after IDLE. instr_data_o=0x00500093 in EXEC. core_en_o pulses in cycle 3. instret_o=1.
- Load at address 0x40, where memory[0x40]=0xDEADBEEF, with 2 wait states on the data access: DATA req is held 3 cycles. mem_data_o=0xDEADBEEF in COMMIT. Total latency 6 cycles.
- Store of 0x12345678 to 0x44: bus_we_o=1, bus_addr_o=0x44 and bus_wdata_o=0x12345678 are held until ack. Exactly one write.
- Spurious bus_ack_i in IDLE and EXEC: no state change, ir unchanged.
- Data address 0x42: err_o=1, no request for 0x42, core_en_o stays 0. rst_i low clears err_o.
- rst_i asserted mid-fetch wait: bus_req_o=0 in the same cycle. ir=NOP, instret_o=0.
